// File: rtl/fifo_seq_ctrl_if.sv
// Weight-source handshake between the upstream producer and fifo_seq_ctrl.
// master = weight source, slave = sequencer.
interface fifo_seq_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fifo_seq_ctrl.sv
// Fill / load / bit-serial shift sequencer for the weight FIFO and its shift stage.
// Optional abort path is compiled in with `define FIFO_SEQ_ABORT_EN.
module fifo_seq_ctrl #(
   parameter int DEPTH  = 64,
   parameter int WIDTH  = 16,
   parameter int PASSES = 12
) (
   input  logic                     clk,
   input  logic                     resetn,
   fifo_seq_ctrl_if.slave           src,
   input  logic                     stall,
`ifdef FIFO_SEQ_ABORT_EN
   input  logic                     abort,
   output logic                     aborted,
`endif
   output logic [WIDTH-1:0]         fifo_w,
   output logic                     fifo_enable,
   output logic                     fifo_load,
   output logic                     fifo_shift,
   output logic                     frame_start,
   output logic [$clog2(WIDTH)-1:0] bit_idx,
   output logic [7:0]               pass_idx,
   output logic                     busy,
   output logic                     done
);
   localparam int WC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW   = $clog2(WIDTH);
   localparam int PW   = $clog2(PASSES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [WC_W-1:0] r_word_cnt;
   logic [BW-1:0]   r_bit_cnt;
   logic [PW-1:0]   r_pass_cnt;
   logic            w_in_ready;
   logic            w_accept;
   logic            w_abort_hit;

   assign w_in_ready = (r_state == S_IDLE) || (r_state == S_FILL);

`ifdef FIFO_SEQ_ABORT_EN
   logic r_aborted;
   assign w_abort_hit = abort && (r_state != S_IDLE);
   assign aborted     = r_aborted;
`else
   assign w_abort_hit = 1'b0;
`endif

   // An aborting cycle must not push a word into the FIFO.
   assign w_accept    = src.in_valid && w_in_ready && !w_abort_hit;

   assign src.in_ready = w_in_ready;
   assign fifo_w       = src.in_data;
   assign fifo_enable  = w_accept;
   assign fifo_load    = (r_state == S_LOAD);
   assign fifo_shift   = (r_state == S_SHIFT) && !stall;
   assign frame_start  = (r_state == S_SHIFT) && !stall && (r_bit_cnt == BW'(WIDTH - 1));
   assign bit_idx      = r_bit_cnt;
   assign pass_idx     = 8'(r_pass_cnt);
   assign busy         = (r_state != S_IDLE);
   assign done         = (r_state == S_DONE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_word_cnt <= '0;
         r_bit_cnt  <= BW'(WIDTH - 1);
         r_pass_cnt <= '0;
`ifdef FIFO_SEQ_ABORT_EN
         r_aborted  <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_word_cnt <= WC_W'(1);
                  r_state    <= S_FILL;
               end
            end
            S_FILL: begin
               if (w_accept) begin
                  if (r_word_cnt == WC_W'(DEPTH - 1)) begin
                     r_word_cnt <= '0;
                     r_state    <= S_LOAD;
                  end else begin
                     r_word_cnt <= r_word_cnt + 1'b1;
                  end
               end
            end
            S_LOAD: begin
               r_bit_cnt <= BW'(WIDTH - 1);
               r_state   <= S_SHIFT;
            end
            S_SHIFT: begin
               if (!stall) begin
                  if (r_bit_cnt != '0) begin
                     r_bit_cnt <= r_bit_cnt - 1'b1;
                  end else if (r_pass_cnt == PW'(PASSES - 1)) begin
                     r_bit_cnt <= BW'(WIDTH - 1);
                     r_state   <= S_DONE;
                  end else begin
                     r_pass_cnt <= r_pass_cnt + 1'b1;
                     r_bit_cnt  <= BW'(WIDTH - 1);
                     r_state    <= S_LOAD;
                  end
               end
            end
            S_DONE: begin
               r_pass_cnt <= '0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
`ifdef FIFO_SEQ_ABORT_EN
         // Placed after the case so the abort overrides every other update.
         r_aborted <= w_abort_hit;
         if (w_abort_hit) begin
            r_state    <= S_IDLE;
            r_word_cnt <= '0;
            r_bit_cnt  <= BW'(WIDTH - 1);
            r_pass_cnt <= '0;
         end
`endif
      end
   end
endmodule
